// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display path.
// Segment encodings are active-low, bit 6 = segment a.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low abcdefg segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits over one segment bus,
// with a blanking guard at the start of every slot and a frame-complete strobe.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 10,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg7,
    output logic                    frame_done
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TW-1:0]   TICK_LAST        = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0]   TICK_FIRST_DRIVE = TW'(BLANK_CYCLES);
    localparam logic [SW-1:0]   SLOT_LAST        = SW'(NUM_DIGITS - 1);
    localparam scan_state_t     STATE_START      = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    scan_state_t            r_state;
    logic [TW-1:0]          r_tick;
    logic [SW-1:0]          r_slot;
    logic [3:0]             r_val;
    logic                   r_en;
    logic [NUM_DIGITS-1:0]  r_an;
    logic [6:0]             r_seg;
    logic                   r_frame_done;

    scan_state_t            w_state_nxt;
    logic [TW-1:0]          w_tick_nxt;
    logic [SW-1:0]          w_slot_nxt;
    logic                   w_latch;
    logic [3:0]             w_val_nxt;
    logic                   w_en_nxt;
    logic [6:0]             w_dec;
    logic [NUM_DIGITS-1:0]  w_an_nxt;
    logic [6:0]             w_seg_nxt;
    logic                   w_fd_nxt;

    hex_to_seg7 u_dec (
        .i_hex (w_val_nxt),
        .o_seg (w_dec)
    );

    // Counters hold the position of the cycle about to be presented, so the
    // output registers load that cycle's values on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_tick_nxt  = r_tick + TW'(1);
        if (r_tick == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_slot_nxt  = (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);
            w_state_nxt = STATE_START;
        end else if (w_tick_nxt == TICK_FIRST_DRIVE) begin
            w_state_nxt = DRIVE;
        end

        w_latch   = (r_state == DRIVE) && (r_tick == TICK_FIRST_DRIVE);
        w_val_nxt = w_latch ? digits[{r_slot, 2'b00} +: 4] : r_val;
        w_en_nxt  = w_latch ? digit_en[r_slot] : r_en;

        w_an_nxt  = '1;
        w_seg_nxt = SEG_BLANK;
        if ((r_state == DRIVE) && w_en_nxt) begin
            w_an_nxt  = ~(NUM_DIGITS'(1) << r_slot);
            w_seg_nxt = w_dec;
        end

        w_fd_nxt = (r_slot == SLOT_LAST) && (r_tick == TICK_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= STATE_START;
            r_tick       <= '0;
            r_slot       <= '0;
            r_val        <= '0;
            r_en         <= 1'b0;
            r_an         <= '1;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_slot       <= w_slot_nxt;
            r_val        <= w_val_nxt;
            r_en         <= w_en_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    assign an         = r_an;
    assign seg7       = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: default instance plus a 2-digit,
// no-blank, 4-cycle-slot instance, both checked against a cycle-index model.
module tb_seg7_scan_ctrl;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dig1 = '0;
    logic [3:0]  en1  = '0;
    logic [7:0]  dig2 = '0;
    logic [1:0]  en2  = '0;
    logic [3:0]  an1;
    logic [6:0]  seg1;
    logic        fd1;
    logic [1:0]  an2;
    logic [6:0]  seg2;
    logic        fd2;

    int vectors   = 0;
    int miscompares = 0;
    int k = 0;

    exp_t q1[$];
    exp_t q2[$];

    logic [3:0] lv [2][8];
    logic       le [2][8];

    logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 clk = ~clk;

    seg7_scan_ctrl dut1 (
        .clk        (clk),
        .rst        (rst),
        .digits     (dig1),
        .digit_en   (en1),
        .an         (an1),
        .seg7       (seg1),
        .frame_done (fd1)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS   (2),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (0)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .digits     (dig2),
        .digit_en   (en2),
        .an         (an2),
        .seg7       (seg2),
        .frame_done (fd2)
    );

    // Cycle kk of a frame: slot = (kk/R)%N, position in slot = kk%R.
    // Each slot captures its own digit and enable at position B.
    task automatic model(input int d, input int kk, input int R, input int B, input int N,
                         input logic [31:0] dg, input logic [7:0] en, output exp_t e);
        int p = kk % R;
        int s = (kk / R) % N;
        int all = (1 << N) - 1;
        if (p == B) begin
            lv[d][s] = dg[4*s +: 4];
            le[d][s] = en[s];
        end
        e.fd = (s == N - 1) && (p == R - 1);
        if (p < B || !le[d][s]) begin
            e.an  = 8'(all);
            e.seg = 7'b1111111;
        end else begin
            e.an  = 8'(all & ~(1 << s));
            e.seg = SEG[lv[d][s]];
        end
    endtask

    task automatic check(input string name, input exp_t got, input exp_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s k=%0d: got an=%b seg=%b fd=%b, want an=%b seg=%b fd=%b",
                     name, k, got.an, got.seg, got.fd, want.an, want.seg, want.fd);
        end
    endtask

    task automatic step();
        exp_t e;
        model(0, k, 10, 1, 4, {16'b0, dig1}, {4'b0, en1}, e);
        q1.push_back(e);
        model(1, k, 4, 0, 2, {24'b0, dig2}, {6'b0, en2}, e);
        q2.push_back(e);
        k++;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 8; s++) begin
                lv[d][s] = '0;
                le[d][s] = 1'b0;
            end
        k = 0;
    endtask

    // Monitor: every non-reset cycle the DUTs present a display word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q1.size() > 0) begin
                e = q1.pop_front();
                check("dut1", {4'b0, an1, seg1, fd1}, e);
            end
            if (!rst && q2.size() > 0) begin
                e = q2.pop_front();
                check("dut2", {6'b0, an2, seg2, fd2}, e);
            end
        end
    end

    initial begin
        exp_t blank1, blank2;
        blank1 = {8'h0F, 7'b1111111, 1'b0};
        blank2 = {8'h03, 7'b1111111, 1'b0};
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check("reset1", {4'b0, an1, seg1, fd1}, blank1);
        check("reset2", {6'b0, an2, seg2, fd2}, blank2);
        @(negedge clk);

        dig1 = 16'h3210; en1 = 4'b1111;
        dig2 = 8'hA5;    en2 = 2'b11;
        rst  = 1'b0;
        repeat (40) step();

        dig1 = 16'hFEDC; en1 = 4'b1010;
        repeat (40) step();

        dig1 = 16'h0008; en1 = 4'b1111;
        repeat (50) begin
            if (k % 40 == 5) dig1 = 16'h0009;
            step();
        end

        repeat (200) begin
            if ($urandom_range(0, 3) == 0) begin
                dig1 = 16'($urandom);
                en1  = 4'($urandom);
                dig2 = 8'($urandom);
                en2  = 2'($urandom);
            end
            step();
        end

        // Re-align so the asynchronous reset lands mid slot 2.
        @(negedge clk);
        rst = 1'b1;
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        repeat (24) step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst1", {4'b0, an1, seg1, fd1}, blank1);
        check("async_rst2", {6'b0, an2, seg2, fd2}, blank2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_model();
        repeat (120) begin
            if ($urandom_range(0, 2) == 0) begin
                dig1 = 16'($urandom);
                en1  = 4'($urandom);
                dig2 = 8'($urandom);
                en2  = 2'($urandom);
            end
            step();
        end

        @(negedge clk);
        vectors++;
        if (q1.size() != 0 || q2.size() != 0) begin
            miscompares++;
            $display("FAIL drain: q1=%0d q2=%0d pending, want 0", q1.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scheduler that shares one 7-segment decoder and segment bus among NUM_DIGITS common-anode digits. It sits between the lab counter datapaths (each producing a 4-bit hex value) and the board display pins. It rotates digit ownership on a fixed refresh schedule and inserts a blanking guard between slots to prevent ghosting. A one-cycle frame strobe marks each completed scan.

## Interface
- NUM_DIGITS, 4: number of digits scanned; 2..8.
- REFRESH_DIV, 10: clock cycles per digit slot, including blanking; must be > BLANK_CYCLES.
- BLANK_CYCLES, 1: cycles at the start of each slot with all anodes off; 0 disables blanking.
- clk  input  1: single clock, rising edge.
- rst  input  1: reset, asynchronous, active-high.
- digits  input  4*NUM_DIGITS: hex value per digit; digit i = digits[4i+3:4i].
- digit_en  input  NUM_DIGITS: 1 = digit i is shown; 0 = its slot runs but stays dark.
- an  output  NUM_DIGITS: anode selects, active-low, one-hot-low or all 1.
- seg7  output  7: segments a..g (bit 6 = a), active-low.
- frame_done  output  1: one-cycle pulse on the last cycle of the final slot.

## Operation
- State per slot: BLANK (BLANK_CYCLES cycles), then DRIVE (REFRESH_DIV-BLANK_CYCLES cycles).
- Slot index runs 0..NUM_DIGITS-1 and wraps to 0. All slots take equal time, so the refresh rate is constant regardless of digit_en.
- On the BLANK->DRIVE transition, the controller latches digits[slot] and digit_en[slot]. Changes to either input mid-slot have no effect until that digit's next slot.
- BLANK: an = all 1, seg7 = 7'b1111111.
- DRIVE with latched enable = 1: an bit slot = 0, others 1; seg7 = decode(latched value).
- DRIVE with latched enable = 0: an all 1, seg7 = 7'b1111111.
- Decode (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- With BLANK_CYCLES = 0, BLANK is skipped. The latch happens on the first cycle of each slot.
- Reset (asynchronous, any time, including mid-slot): slot = 0, tick = 0, state = BLANK (or DRIVE if BLANK_CYCLES = 0), an = all 1, seg7 = 7'b1111111, frame_done = 0. The latched value and enable clear to 0.

## Timing
- Cycle k = the k-th cycle after the first rising edge with rst low (k = 0 is the first cycle).
- All outputs are registered; no combinational path from inputs to outputs.
- Slot s occupies cycles s*REFRESH_DIV .. s*REFRESH_DIV+REFRESH_DIV-1 within a frame of NUM_DIGITS*REFRESH_DIV cycles.
- Defaults give a 40-cycle frame. Cycle 0 is blank; cycles 1-9 drive digit 0; cycle 10 is blank; cycles 11-19 drive digit 1; and so on.
- frame_done is high only in cycle 39 (mod 40). Cycle 40 is blank again with slot = 0.
- Input-to-display latency: the value present at the rising edge that ends slot s's last BLANK cycle appears in the next cycle.
- Tick counter width is $clog2(REFRESH_DIV); the slot counter width is $clog2(NUM_DIGITS), minimum 1.

## Structure
- Package seg7_pkg:
  - SEG_BLANK = 7'b1111111.
  - The 16-entry hex-to-segment constant table.
  - The scan state enum {BLANK, DRIVE}.
- Sub-module hex_to_seg7: combinational 4-bit to 7-bit decoder using the package table. It is reused by the existing single-digit counter top.
- seg7_scan_ctrl holds the tick counter, slot counter, state register, latch and output registers.

## Test plan
- Default params, digits=16'h3210, digit_en=4'b1111 -> cycles 1-9: an=1110, seg7=0000001; cycles 11-19: an=1101, seg7=1001111; cycles 31-39: an=0111, seg7=0000110; frame_done only at cycle 39; cycles 0, 10, 20, 30: an=1111, seg7=1111111.
- digits=16'hFEDC, digit_en=4'b1010 -> slots 0 and 2 stay dark (an=1111); slot 1 shows an=1101, seg7=1000010 (d); slot 3 shows an=0111, seg7=0111000 (F); frame length unchanged at 40.
- Change digit 0 from 8 to 9 at cycle 5 -> cycles 5-9 still show 0000000; cycles 41-49 show 0000100.
- Assert rst asynchronously at cycle 23 (mid slot 2) for 3 cycles -> an=1111, seg7=1111111, frame_done=0 immediately; after release, slot 0 restarts with blank at cycle 0 and drives in cycles 1-9.
- BLANK_CYCLES=0, REFRESH_DIV=4, NUM_DIGITS=2, digits=8'hA5 -> cycles 0-3: an=10, seg7=0100100; cycles 4-7: an=01, seg7=0001000; frame_done at cycle 7.
